isa_bus_master: RTL and testbench
=================================

Name: isa_bus_master

Overview:
- ISA bus initiator: turns single-beat host requests into ISA I/O and memory read/write cycles.
- Drives address, AEN, the four active-low strobes and write data; samples read data and IOCHRDY.
- Bench and integration counterpart of the card-side targets (MDA/CGA): it drives their bus_a/bus_*_l/bus_d/bus_aen inputs and captures their bus_out.
- Strobe widths are long enough for the targets' strobe synchronizers and VRAM slot arbitration.

Parameters:
- ADDR_SETUP, 2: cycles address/AEN/write data are valid before the strobe falls; must be >=1.
- STROBE_CYCLES, 8: minimum strobe-low cycles; must be >=1.
- HOLD_CYCLES, 2: cycles address/data are held after the strobe rises; must be >=1.
- RDY_TIMEOUT, 255: maximum extra wait cycles while bus_rdy is low; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_l  in  1  reset; asynchronous, active-low
- req_valid  in  1  host request valid
- req_ready  out  1  master idle and able to accept
- req_write  in  1  1=write, 0=read
- req_io  in  1  1=I/O space, 0=memory space
- req_addr  in  20  cycle address
- req_wdata  in  8  write data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  8  read data; 0 for writes
- resp_timeout  out  1  qualifies resp_valid; cycle ended by timeout
- bus_a  out  20  ISA address
- bus_aen  out  1  address enable; 1 when idle, 0 during own cycles
- bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  out  1 each  strobes
- bus_d_out  out  8  write data to targets
- bus_d_oe  out  1  master drives data bus
- bus_d_in  in  8  read data from targets
- bus_rdy  in  1  IOCHRDY; 0 stretches the strobe

Behaviour:
- Reset (async assert, sync release):
  - all strobes 1, bus_aen=1, bus_a=0, bus_d_out=0, bus_d_oe=0.
  - req_ready=0 while reset_l=0.
  - resp_valid=0, resp_rdata=0, resp_timeout=0.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready at edge E0, latch addr/wdata/type and go to SETUP.
  - SETUP: bus_a=addr, bus_aen=0, bus_d_oe=req_write, bus_d_out=wdata. Lasts ADDR_SETUP cycles, then STROBE.
  - STROBE: the single strobe selected by {req_io, req_write} is 0 for STROBE_CYCLES. At the end of the count: if bus_rdy=1, go to HOLD; else go to WAIT.
  - WAIT: strobe stays low; wait counter increments each cycle.
    - bus_rdy=1: go to HOLD.
    - RDY_TIMEOUT!=0 and count==RDY_TIMEOUT: go to HOLD with timeout flag set.
  - HOLD: strobe 1; address, AEN=0 and write data held for HOLD_CYCLES; then IDLE.
- Read capture: bus_d_in is registered on the last strobe-low cycle, i.e. the edge at which the strobe rises.
- Completion:
  - resp_valid pulses for exactly one cycle on the first IDLE cycle, together with req_ready=1.
  - resp_rdata and resp_timeout hold their values until the next completion.
- Latency with bus_rdy=1: resp_valid occurs ADDR_SETUP+STROBE_CYCLES+HOLD_CYCLES+1 cycles after E0 (13 with defaults).
- Exactly one strobe is ever low. Strobes are never low in SETUP, HOLD or IDLE.
- Back-to-back: a request held valid during the resp_valid cycle is accepted that cycle. bus_aen returns to 1 for at least that one cycle.
- bus_rdy is ignored outside STROBE/WAIT.
- On entering IDLE, bus_aen returns to 1 and bus_d_oe to 0. bus_a keeps its last value.
- Counters are 8 bits, reloaded on each state entry. Parameter values >255 are illegal.
- Reset mid-cycle: strobes go high asynchronously, no resp_valid is produced, the request is dropped.

Decomposition:
- Package isa_pkg:
  - state enum IDLE/SETUP/STROBE/WAIT/HOLD.
  - cycle-type encoding {io, write}.
  - counter width constant CNT_W=8.
- No sub-module; one FSM plus one shared down-counter.

Test Plan:
- IO write 0x3B4<=0x0E: bus_iow_l low for exactly 8 cycles with bus_a=0x003B4, bus_aen=0, bus_d_out=0x0E; resp_valid 13 cycles after accept, resp_rdata=0.
- IO read 0x3BA with target returning 0xF9: bus_ior_l low 8 cycles; resp_rdata=0xF9, resp_timeout=0.
- Memory write 0xB0000<=0x41, then read 0xB0000 back-to-back (req_valid held): bus_memw_l then bus_memr_l; bus_aen=1 for exactly one cycle between the two cycles; read returns 0x41.
- bus_rdy held low for 5 cycles past the strobe count: strobe low 13 cycles; data captured at strobe rise; resp_timeout=0.
- bus_rdy stuck low with RDY_TIMEOUT=4: strobe low 8+4 cycles, then HOLD; resp_valid with resp_timeout=1.
- reset_l dropped during STROBE: strobe high in the same cycle (async); no resp_valid; after release req_ready=1 and bus_aen=1.

Source files
------------

// File: rtl/isa_bus_master_pkg.sv
// Shared types for the ISA bus initiator: FSM states, cycle-type encoding
// and the width of the shared phase counter.
package isa_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    HOLD
  } state_t;

  // {io, write}
  typedef enum logic [1:0] {
    CYC_MEMR = 2'b00,
    CYC_MEMW = 2'b01,
    CYC_IOR  = 2'b10,
    CYC_IOW  = 2'b11
  } cyc_t;

  // Phases last N cycles and leave on counter==0, so the load value is N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/isa_bus_master.sv
// ISA bus initiator: runs one host request as an I/O or memory cycle with
// address setup, stretchable strobe (IOCHRDY) and address/data hold.
//
// state  | meaning
// IDLE   | AEN high, host may issue a request
// SETUP  | address/AEN/write data valid, strobe still high
// STROBE | selected strobe low for the minimum width
// WAIT   | strobe stretched while IOCHRDY is low, optional timeout
// HOLD   | strobe high, address/data still driven
module isa_bus_master
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_SETUP    = 2,
  parameter int unsigned STROBE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter int unsigned RDY_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_timeout,
  output logic [19:0] bus_a,
  output logic        bus_aen,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  input  logic        bus_rdy
);

  localparam logic [CNT_W-1:0] SETUP_LD  = cnt_load(ADDR_SETUP);
  localparam logic [CNT_W-1:0] STROBE_LD = cnt_load(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LD   = cnt_load(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LD   = cnt_load(RDY_TIMEOUT);
  localparam logic             TO_EN     = (RDY_TIMEOUT != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cyc_t             cyc_q, cyc_d;
  logic [19:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       cap_q, cap_d;
  logic             to_flag_q, to_flag_d;
  logic             resp_valid_q, resp_valid_d;
  logic [7:0]       resp_rdata_q, resp_rdata_d;
  logic             resp_timeout_q, resp_timeout_d;
  logic             rst_done_q;
  logic             strobe_on;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cyc_q          <= CYC_MEMR;
      addr_q         <= '0;
      wdata_q        <= '0;
      cap_q          <= '0;
      to_flag_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_timeout_q <= 1'b0;
      rst_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cyc_q          <= cyc_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cap_q          <= cap_d;
      to_flag_q      <= to_flag_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_timeout_q <= resp_timeout_d;
      rst_done_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cyc_d          = cyc_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cap_d          = cap_q;
    to_flag_d      = to_flag_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    resp_timeout_d = resp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          cyc_d     = cyc_t'({req_io, req_write});
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          to_flag_d = 1'b0;
          cnt_d     = SETUP_LD;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bus_rdy) begin
          cap_d   = cyc_q[0] ? 8'h00 : bus_d_in;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d   = WAIT_LD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Timeout still captures whatever is on the bus so the host sees a defined value.
        if (bus_rdy || (TO_EN && cnt_q == '0)) begin
          cap_d     = cyc_q[0] ? 8'h00 : bus_d_in;
          to_flag_d = !bus_rdy;
          cnt_d     = HOLD_LD;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          resp_valid_d   = 1'b1;
          resp_rdata_d   = cap_q;
          resp_timeout_d = to_flag_q;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state flop so reset raises them immediately.
  assign strobe_on    = (state_q == STROBE) || (state_q == WAIT);
  assign bus_memr_l   = !(strobe_on && cyc_q == CYC_MEMR);
  assign bus_memw_l   = !(strobe_on && cyc_q == CYC_MEMW);
  assign bus_ior_l    = !(strobe_on && cyc_q == CYC_IOR);
  assign bus_iow_l    = !(strobe_on && cyc_q == CYC_IOW);
  assign bus_aen      = (state_q == IDLE);
  assign bus_a        = addr_q;
  assign bus_d_out    = wdata_q;
  assign bus_d_oe     = (state_q != IDLE) && cyc_q[0];
  assign req_ready    = (state_q == IDLE) && rst_done_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_isa_bus_master.sv
// Scoreboard bench for isa_bus_master: a default instance plus one with a
// short IOCHRDY timeout, driven through a small model of an ISA target.
module tb_isa_bus_master;

  typedef struct {
    logic [7:0] rdata;
    logic       to;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        req_valid, req_write, req_io, sel_to;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  bus_d_in;
  logic        bus_rdy;

  logic        m_ready, m_rv, m_rto, m_aen, m_ior, m_iow, m_memr, m_memw, m_oe;
  logic [7:0]  m_rdata, m_dout;
  logic [19:0] m_a;
  logic        t_ready, t_rv, t_rto, t_aen, t_ior, t_iow, t_memr, t_memw, t_oe;
  logic [7:0]  t_rdata, t_dout;
  logic [19:0] t_a;

  logic        mon_ready, mon_rv, mon_rto, mon_aen, mon_ior, mon_iow, mon_memr, mon_memw, mon_oe;
  logic [7:0]  mon_rdata, mon_dout;
  logic [19:0] mon_a;
  logic        mon_strobe_low;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        sb[$];
  int          acc_q[$];

  logic [7:0]  low_cnt = 8'd0;
  int          rdy_hold_n = 0;
  logic        rd_mode = 1'b0;
  logic [7:0]  io_val = 8'h00;
  logic [19:0] mem_a = 20'h0;
  logic [7:0]  mem_d = 8'h00;
  int          run[4] = '{0, 0, 0, 0};
  int          last_w[4] = '{0, 0, 0, 0};
  int          gap = 0;
  int          last_gap = 0;
  logic [19:0] snap_a;
  logic        snap_aen, snap_oe;
  logic [7:0]  snap_dout;

  always #5 clk = ~clk;

  isa_bus_master dut (
    .clk(clk), .reset_l(reset_l),
    .req_valid(req_valid && !sel_to), .req_ready(m_ready),
    .req_write(req_write), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(m_rv), .resp_rdata(m_rdata), .resp_timeout(m_rto),
    .bus_a(m_a), .bus_aen(m_aen), .bus_ior_l(m_ior), .bus_iow_l(m_iow),
    .bus_memr_l(m_memr), .bus_memw_l(m_memw), .bus_d_out(m_dout), .bus_d_oe(m_oe),
    .bus_d_in(bus_d_in), .bus_rdy(bus_rdy)
  );

  isa_bus_master #(.RDY_TIMEOUT(4)) dut_to (
    .clk(clk), .reset_l(reset_l),
    .req_valid(req_valid && sel_to), .req_ready(t_ready),
    .req_write(req_write), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(t_rv), .resp_rdata(t_rdata), .resp_timeout(t_rto),
    .bus_a(t_a), .bus_aen(t_aen), .bus_ior_l(t_ior), .bus_iow_l(t_iow),
    .bus_memr_l(t_memr), .bus_memw_l(t_memw), .bus_d_out(t_dout), .bus_d_oe(t_oe),
    .bus_d_in(bus_d_in), .bus_rdy(bus_rdy)
  );

  assign mon_ready = sel_to ? t_ready : m_ready;
  assign mon_rv    = sel_to ? t_rv    : m_rv;
  assign mon_rto   = sel_to ? t_rto   : m_rto;
  assign mon_rdata = sel_to ? t_rdata : m_rdata;
  assign mon_aen   = sel_to ? t_aen   : m_aen;
  assign mon_ior   = sel_to ? t_ior   : m_ior;
  assign mon_iow   = sel_to ? t_iow   : m_iow;
  assign mon_memr  = sel_to ? t_memr  : m_memr;
  assign mon_memw  = sel_to ? t_memw  : m_memw;
  assign mon_oe    = sel_to ? t_oe    : m_oe;
  assign mon_dout  = sel_to ? t_dout  : m_dout;
  assign mon_a     = sel_to ? t_a     : m_a;
  assign mon_strobe_low = !(mon_ior && mon_iow && mon_memr && mon_memw);

  // Target model: IOCHRDY low from the 8th strobe-low cycle for rdy_hold_n cycles.
  assign bus_rdy = !(mon_strobe_low && low_cnt >= 8'd7 && int'(low_cnt) < 7 + rdy_hold_n);

  always_comb begin
    bus_d_in = 8'hFF;
    if (!mon_ior)       bus_d_in = rd_mode ? 8'h50 + low_cnt : io_val;
    else if (!mon_memr) bus_d_in = (mon_a == mem_a) ? mem_d : 8'hEE;
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    low_cnt <= mon_strobe_low ? low_cnt + 8'd1 : 8'd0;
  end

  always @(negedge clk) begin
    logic [3:0] lo;
    exp_t       e;
    int         a;
    lo = ~{mon_iow, mon_ior, mon_memw, mon_memr};
    if (reset_l) begin
      if (mon_rv) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
          n_checks++;
          if (mon_rdata !== e.rdata) begin
            n_fail++; $display("FAIL resp_rdata: got %h want %h", mon_rdata, e.rdata);
          end
          n_checks++;
          if (mon_rto !== e.to) begin
            n_fail++; $display("FAIL resp_timeout: got %b want %b", mon_rto, e.to);
          end
          n_checks++;
          if (cyc - a + 1 != e.lat) begin
            n_fail++; $display("FAIL resp_latency: got %0d want %0d", cyc - a + 1, e.lat);
          end
        end
      end
      if (req_valid && mon_ready) acc_q.push_back(cyc + 1);
    end
    n_checks++;
    if ($countones(lo) > 1 || (lo != 4'b0 && mon_aen !== 1'b0)) begin
      n_fail++; $display("FAIL strobe_excl: strobes_low=%b aen=%b want <=1 low with aen=0", lo, mon_aen);
    end
    for (int s = 0; s < 4; s++) begin
      if (lo[s]) run[s]++;
      else if (run[s] > 0) begin last_w[s] = run[s]; run[s] = 0; end
    end
    if (lo != 4'b0) begin
      snap_a = mon_a; snap_aen = mon_aen; snap_oe = mon_oe; snap_dout = mon_dout;
    end
    if (!mon_memw) begin mem_a <= mon_a; mem_d <= mon_dout; end
    if (mon_aen) gap++;
    else if (gap > 0) begin last_gap = gap; gap = 0; end
  end

  task automatic wait_ready();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (mon_ready) break;
    end
    if (k == 100) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, want 1", k);
    end
  endtask

  task automatic drive(input logic w, input logic io, input logic [19:0] a, input logic [7:0] d,
                       input logic [7:0] er, input logic eto, input int elat);
    req_write = w; req_io = io; req_addr = a; req_wdata = d; req_valid = 1'b1;
    sb.push_back('{rdata: er, to: eto, lat: elat});
  endtask

  task automatic single(input logic w, input logic io, input logic [19:0] a, input logic [7:0] d,
                        input logic [7:0] er, input logic eto, input int elat);
    @(posedge clk); #1;
    drive(w, io, a, d, er, eto, elat);
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 400 && sb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL resp_timeout_wait: %0d responses outstanding, want 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({m_ior, m_iow, m_memr, m_memw, m_aen, m_oe, m_ready} !== 7'b1111100) begin
      n_fail++; $display("FAIL reset_ctrl: strobes/aen/oe/ready=%b want 1111100",
                         {m_ior, m_iow, m_memr, m_memw, m_aen, m_oe, m_ready});
    end
    n_checks++;
    if (m_a !== 20'h0 || m_dout !== 8'h00) begin
      n_fail++; $display("FAIL reset_bus: bus_a=%h d_out=%h want 0", m_a, m_dout);
    end
    n_checks++;
    if (m_rv !== 1'b0 || m_rdata !== 8'h00 || m_rto !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp: rv=%b rdata=%h to=%b want 0", m_rv, m_rdata, m_rto);
    end
    repeat (2) @(posedge clk);
    #1 reset_l = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_aen !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: ready=%b aen=%b want 1 1", m_ready, m_aen);
    end
  endtask

  task automatic test_io_write();
    single(1'b1, 1'b1, 20'h003B4, 8'h0E, 8'h00, 1'b0, 13);
    wait_done();
    n_checks++;
    if (last_w[3] != 8) begin
      n_fail++; $display("FAIL iow_width: got %0d want 8", last_w[3]);
    end
    n_checks++;
    if (snap_a !== 20'h003B4 || snap_aen !== 1'b0 || snap_dout !== 8'h0E || snap_oe !== 1'b1) begin
      n_fail++; $display("FAIL iow_bus: a=%h aen=%b d=%h oe=%b want 003b4 0 0e 1",
                         snap_a, snap_aen, snap_dout, snap_oe);
    end
    n_checks++;
    if (m_aen !== 1'b1 || m_oe !== 1'b0 || m_a !== 20'h003B4) begin
      n_fail++; $display("FAIL iow_idle: aen=%b oe=%b a=%h want 1 0 003b4", m_aen, m_oe, m_a);
    end
  endtask

  task automatic test_io_read();
    io_val = 8'hF9;
    single(1'b0, 1'b1, 20'h003BA, 8'h00, 8'hF9, 1'b0, 13);
    wait_done();
    n_checks++;
    if (last_w[2] != 8 || snap_oe !== 1'b0 || snap_a !== 20'h003BA) begin
      n_fail++; $display("FAIL ior_strobe: width=%0d oe=%b a=%h want 8 0 003ba", last_w[2], snap_oe, snap_a);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 20'hB0000, 8'h41, 8'h00, 1'b0, 13);
    wait_ready();
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 20'hB0000, 8'h00, 8'h41, 1'b0, 13);
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done();
    n_checks++;
    if (last_w[1] != 8 || last_w[0] != 8) begin
      n_fail++; $display("FAIL mem_widths: memw=%0d memr=%0d want 8 8", last_w[1], last_w[0]);
    end
    n_checks++;
    if (last_gap != 1) begin
      n_fail++; $display("FAIL b2b_aen_gap: got %0d want 1", last_gap);
    end
  endtask

  task automatic test_rdy_stretch();
    rd_mode = 1'b1; rdy_hold_n = 5;
    single(1'b0, 1'b1, 20'h00300, 8'h00, 8'h5C, 1'b0, 18);
    wait_done();
    n_checks++;
    if (last_w[2] != 13) begin
      n_fail++; $display("FAIL stretch_width: got %0d want 13", last_w[2]);
    end
    rd_mode = 1'b0; rdy_hold_n = 0;
  endtask

  task automatic test_timeout();
    sel_to = 1'b1; rd_mode = 1'b1; rdy_hold_n = 200;
    repeat (2) @(negedge clk);
    single(1'b0, 1'b1, 20'h00301, 8'h00, 8'h5B, 1'b1, 17);
    wait_done();
    n_checks++;
    if (last_w[2] != 12) begin
      n_fail++; $display("FAIL timeout_width: got %0d want 12", last_w[2]);
    end
    rd_mode = 1'b0; rdy_hold_n = 0;
    repeat (2) @(negedge clk);
    sel_to = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 20'h003D4, 8'h77, 8'h00, 1'b0, 13);
    for (k = 0; k < 50 && m_iow !== 1'b0; k++) @(negedge clk);
    req_valid = 1'b0;
    #2 reset_l = 1'b0;
    sb.delete(); acc_q.delete();
    #1;
    n_checks++;
    if (m_iow !== 1'b1 || k == 50) begin
      n_fail++; $display("FAIL reset_async: iow=%b (wait=%0d) want 1", m_iow, k);
    end
    n_checks++;
    if (m_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", m_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset_l = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_aen !== 1'b1 || sb.size() != 0) begin
      n_fail++; $display("FAIL reset_recover: ready=%b aen=%b want 1 1", m_ready, m_aen);
    end
  endtask

  initial begin
    reset_l = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; sel_to = 1'b0;
    test_reset();
    test_io_write();
    test_io_read();
    test_back_to_back();
    test_rdy_stretch();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
